// File: rtl/light_switch_pkg.sv
// Shared types for the light switch controller.
package light_switch_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_WARN = 2'b10
    } state_t;

endpackage

// File: rtl/light_switch_if.sv
// Switch/LED signal bundle between the board pins and the light switch controller.
interface light_switch_if;

    logic       sw;
    logic       auto_off_en;
    logic       led;
    logic [1:0] state;
    logic       press;

    modport master (output sw, output auto_off_en, input led, input state, input press);
    modport slave  (input sw, input auto_off_en, output led, output state, output press);

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser, stability-count debouncer and registered rising-edge pulse.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          db_prev;
    logic [CW-1:0] cnt;

    // Level only follows the synchronised input after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sw_db      <= 1'b0;
            cnt        <= '0;
            db_prev    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 == sw_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                sw_db <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            db_prev    <= sw_db;
            rise_pulse <= sw_db & ~db_prev;
        end
    end

endmodule

// File: rtl/light_switch_ctrl.sv
// Push-to-toggle LED controller with optional auto-off timeout and pre-off warning phase.
// Define LIGHT_SWITCH_BLINK_WARN_EN to blink the LED during the warning phase.
module light_switch_ctrl
    import light_switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned AUTO_OFF_CYCLES   = 500000000,
    parameter int unsigned WARN_CYCLES       = 100000000,
    parameter int unsigned BLINK_HALF_CYCLES = 12500000
) (
    input logic           clk,
    input logic           rst_n,
    light_switch_if.slave bus
);

    localparam int unsigned TW = $clog2(AUTO_OFF_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || WARN_CYCLES < 1 || WARN_CYCLES >= AUTO_OFF_CYCLES ||
        BLINK_HALF_CYCLES < 1) begin : g_bad_params
        $error("light_switch_ctrl: invalid parameter set");
    end

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_dec;
    logic          tick;
    logic          sw_db;
    logic          press_evt;
    logic          warn_led;
    logic          led_d;

    switch_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (bus.sw),
        .sw_db      (sw_db),
        .rise_pulse (bus.press)
    );

    // A pulse always coincides with a high clean level; qualifying keeps the FSM tied to it.
    assign press_evt = bus.press & sw_db;

    // Next state and timer; a press takes priority over any timer event in the same cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timer_dec = timer_q - TW'(1);
        tick      = (state_q != ST_OFF) && bus.auto_off_en && (timer_q != '0);
        unique case (state_q)
            ST_OFF: begin
                if (press_evt) state_d = ST_ON;
            end
            ST_ON: begin
                if (press_evt) state_d = ST_OFF;
                else if (tick && timer_dec == TW'(WARN_CYCLES)) state_d = ST_WARN;
            end
            ST_WARN: begin
                if (press_evt || !bus.auto_off_en) state_d = ST_ON;
                else if (tick && timer_dec == '0) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        if (state_d == ST_ON && state_q != ST_ON) begin
            timer_d = TW'(AUTO_OFF_CYCLES);
        end else if (tick) begin
            timer_d = timer_dec;
        end
    end

`ifdef LIGHT_SWITCH_BLINK_WARN_EN
    localparam int unsigned BW = $clog2(BLINK_HALF_CYCLES + 1);

    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_q;
    logic          blink_d;

    // Phase starts high on WARN entry and flips every BLINK_HALF_CYCLES cycles while in WARN.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == ST_WARN) begin
            if (state_q != ST_WARN) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BW'(BLINK_HALF_CYCLES - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign warn_led = blink_d;
`else
    assign warn_led = 1'b1;
`endif

    assign led_d = (state_d == ST_ON) || ((state_d == ST_WARN) && warn_led);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            timer_q <= '0;
            bus.led <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bus.led <= led_d;
        end
    end

    assign bus.state = 2'(state_q);

endmodule

// File: tb/tb_light_switch_ctrl.sv
// Directed vector bench for light_switch_ctrl (DEBOUNCE=4, AUTO_OFF=20, WARN=6, BLINK_HALF=2).
module tb_light_switch_ctrl;

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_ON   = 2'b01;
    localparam logic [1:0] S_WARN = 2'b10;
`ifdef LIGHT_SWITCH_BLINK_WARN_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct {
        logic       sw;
        logic       en;
        logic       press;
        logic [1:0] state;
        logic       led;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    light_switch_if bus ();

    light_switch_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .AUTO_OFF_CYCLES   (20),
        .WARN_CYCLES       (6),
        .BLINK_HALF_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected led in the i-th WARN cycle: 1,1,0,0,1,1 when blinking, else steady on.
    function automatic logic warn_exp(int i);
        return BLINK ? (((i / 2) % 2) == 0) : 1'b1;
    endfunction

    function automatic void seg(int n, logic sw, logic en, logic pr, logic [1:0] st, logic ld);
        vec_t v;
        v.sw = sw; v.en = en; v.press = pr; v.state = st; v.led = ld;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic void add_warn(logic sw, logic en, int first, int n);
        for (int i = first; i < first + n; i++) seg(1, sw, en, 1'b0, S_WARN, warn_exp(i));
    endfunction

    task automatic check(string name, int row, logic [1:0] act, logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        int press_cnt;
        int press_idx;

        // Toggle on, release, toggle off.
        seg(2, 0, 0, 0, S_OFF, 0);
        seg(7, 1, 0, 0, S_OFF, 0); seg(1, 1, 0, 1, S_OFF, 0); seg(4, 1, 0, 0, S_ON, 1);
        seg(10, 0, 0, 0, S_ON, 1);
        seg(7, 1, 0, 0, S_ON, 1);  seg(1, 1, 0, 1, S_ON, 1);  seg(3, 1, 0, 0, S_OFF, 0);
        seg(10, 0, 0, 0, S_OFF, 0);
        // Short glitches never reach the debounced level.
        for (int g = 0; g < 5; g++) begin
            seg(3, 1, 0, 0, S_OFF, 0); seg(5, 0, 0, 0, S_OFF, 0);
        end
        seg(3, 0, 0, 0, S_OFF, 0);
        // Auto-off: 14 cycles ON, 6 cycles WARN, then OFF.
        seg(7, 1, 1, 0, S_OFF, 0); seg(1, 1, 1, 1, S_OFF, 0); seg(14, 1, 1, 0, S_ON, 1);
        add_warn(1, 1, 0, 6);      seg(3, 1, 1, 0, S_OFF, 0); seg(10, 0, 1, 0, S_OFF, 0);
        // Press lands on the last WARN cycle: back to ON with a full reload.
        seg(7, 1, 1, 0, S_OFF, 0); seg(1, 1, 1, 1, S_OFF, 0); seg(2, 1, 1, 0, S_ON, 1);
        seg(10, 0, 1, 0, S_ON, 1); seg(2, 1, 1, 0, S_ON, 1);  add_warn(1, 1, 0, 5);
        seg(1, 1, 1, 1, S_WARN, warn_exp(5));
        seg(14, 1, 1, 0, S_ON, 1); add_warn(1, 1, 0, 6);      seg(3, 1, 1, 0, S_OFF, 0);
        seg(10, 0, 1, 0, S_OFF, 0);
        // Press lands on the ON->WARN threshold cycle: goes OFF.
        seg(7, 1, 1, 0, S_OFF, 0); seg(1, 1, 1, 1, S_OFF, 0); seg(6, 0, 1, 0, S_ON, 1);
        seg(7, 1, 1, 0, S_ON, 1);  seg(1, 1, 1, 1, S_ON, 1);  seg(3, 1, 1, 0, S_OFF, 0);
        seg(10, 0, 1, 0, S_OFF, 0);
        // Enter WARN, drop auto_off_en -> ON, then hold ON for 100 cycles.
        seg(7, 1, 1, 0, S_OFF, 0); seg(1, 1, 1, 1, S_OFF, 0); seg(14, 1, 1, 0, S_ON, 1);
        add_warn(1, 1, 0, 1);      seg(1, 1, 0, 0, S_ON, 1);  seg(100, 1, 0, 0, S_ON, 1);

        rst_n = 1'b0;
        bus.sw = 1'b0;
        bus.auto_off_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_press", -1, 2'(bus.press), 2'(1'b0));
        check("rst_state", -1, bus.state, S_OFF);
        check("rst_led", -1, 2'(bus.led), 2'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.sw = vecs[i].sw;
            bus.auto_off_en = vecs[i].en;
            @(posedge clk);
            #1;
            check("press", i, 2'(bus.press), 2'(vecs[i].press));
            check("state", i, bus.state, vecs[i].state);
            check("led", i, 2'(bus.led), 2'(vecs[i].led));
        end

        // Asynchronous reset between edges clears outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", -1, bus.state, S_OFF);
        check("async_rst_led", -1, 2'(bus.led), 2'(1'b0));
        check("async_rst_press", -1, 2'(bus.press), 2'(1'b0));

        // sw held high through reset release yields exactly one press, 7 edges after release.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press_cnt = 0;
        press_idx = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.press === 1'b1) begin
                press_cnt++;
                if (press_idx < 0) press_idx = e;
            end
        end
        check("held_press_count", -1, 2'(press_cnt), 2'd1);
        n_cmp++;
        if (press_idx != 7) begin
            n_fail++;
            $display("FAIL held_press_edge: got %0d expected 7", press_idx);
        end
        check("held_state", -1, bus.state, S_ON);
        check("held_led", -1, 2'(bus.led), 2'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/light_switch_ctrl.md
Name: light_switch_ctrl

Overview:
Controller that sequences the board LED from a momentary push switch instead of wiring the switch straight to the LED. It synchronises and debounces the raw switch and turns each clean press into a one-cycle pulse. A three-state FSM toggles the light, with an optional auto-off timeout and a pre-off warning phase. Sits between the board switch pin and the LED pin in the top level.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (>=1)
AUTO_OFF_CYCLES, 500000000, total on-time in cycles after a press when auto-off is enabled
WARN_CYCLES, 100000000, final portion of on-time spent in WARN (1 <= WARN_CYCLES < AUTO_OFF_CYCLES)
BLINK_HALF_CYCLES, 12500000, blink half-period in WARN (used only with BLINK_WARN_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sw  input  1  raw momentary switch, asynchronous, active-high
auto_off_en  input  1  1 = timeout active; 0 = light stays on until the next press
led  output  1  registered LED drive
state  output  2  current FSM state: 00 OFF, 01 ON, 10 WARN
press  output  1  one-cycle pulse on each debounced rising edge of sw

Behaviour:
- Reset (async assert, sync release): state=OFF, led=0, press=0. Sync flops, debounced level, debounce counter, timer and blink phase all cleared.
- Sync: two-flop synchroniser on sw.
- Debounce: counter runs while the synchronised value differs from the debounced level. It clears whenever they match. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- press: registered, high for exactly 1 cycle after a debounced 0->1 transition. A 1->0 transition produces nothing.
- Latency: sw held high from sample edge E gives press high in cycle E+DEBOUNCE_CYCLES+3. led and state update on the following edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- Timer width: $clog2(AUTO_OFF_CYCLES+1).
- Timer: loads AUTO_OFF_CYCLES on every entry to ON. It decrements once per cycle in ON or WARN while auto_off_en=1 and holds while auto_off_en=0.
- FSM transitions:
  - OFF: press -> ON (timer loaded).
  - ON: press -> OFF. Timer decremented to WARN_CYCLES -> WARN.
  - WARN: press -> ON (timer reloaded; extends on-time). Timer decremented to 0 -> OFF. auto_off_en=0 -> ON (reload).
- Timing: on-time without presses is exactly AUTO_OFF_CYCLES cycles. ON lasts AUTO_OFF_CYCLES-WARN_CYCLES cycles and WARN lasts WARN_CYCLES cycles.
- Simultaneous events: press always wins over the timer event in the same cycle.
  - Press in ON on the threshold cycle -> OFF.
  - Press in WARN on the zero cycle -> ON with reload.
- led: 0 in OFF, 1 in ON. In WARN, 1 unless BLINK_WARN_EN is defined.
- Reset mid-operation: immediate OFF, led=0. If sw is held high through reset release, the debounced level starts at 0, so exactly one press is generated DEBOUNCE_CYCLES+3 cycles later.

Optional Feature:
Macro LIGHT_SWITCH_BLINK_WARN_EN.
- Defined: in WARN, led blinks. Blink phase = 1 on WARN entry and toggles every BLINK_HALF_CYCLES cycles via a dedicated counter cleared outside WARN.
- Not defined: blink counter and phase are absent and led=1 throughout WARN.
- All other behaviour is identical either way.

Decomposition:
- Package light_switch_pkg: 2-bit state constants ST_OFF=2'b00, ST_ON=2'b01, ST_WARN=2'b10, and the state typedef.
- One sub-module switch_debouncer: parameter DEBOUNCE_CYCLES; ports clk, rst_n, sw_raw, sw_db, rise_pulse. It contains the synchroniser, debounce counter and edge pulse.
- The FSM, timer, blink logic and led register stay in light_switch_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, AUTO_OFF_CYCLES=20, WARN_CYCLES=6, BLINK_HALF_CYCLES=2.
1. Reset, then sw high at edge 10 and held -> press=1 only in cycle 17; led=1, state=01 from cycle 18. Release and re-press -> led=0, state=00.
2. sw high for 3 cycles then low (glitch), repeated 5 times -> press never asserted; led stays 0.
3. auto_off_en=1, single press -> state 01 for 14 cycles, state 10 for 6 cycles, then 00. led=1 for exactly 20 cycles.
4. Press timed so press coincides with the timer reaching 0 in WARN -> state returns to 01, timer=20, led stays 1. Full 20-cycle on-time restarts.
5. With LIGHT_SWITCH_BLINK_WARN_EN defined, scenario 3 -> led in WARN follows 1,1,0,0,1,1, then 0 in OFF. Without the macro -> led=1 for all 6 WARN cycles.
6. In state 01 with auto_off_en=0 for 100 cycles -> stays 01. Assert rst_n=0 mid-run -> led=0 and state=00 immediately, with no clock edge required.
